// File: rtl/ami_port_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// AMITypes : AMI request/response types plus arbiter id definitions.
// Rev 1.0
// =============================================================================
package AMITypes;

   typedef logic [63:0]  AMIAddr;
   typedef logic [511:0] AMIData;
   typedef logic [63:0]  AMISize;

   typedef struct packed {
      logic   valid;
      logic   isWrite;
      AMIAddr addr;
      AMIData data;
      AMISize size;
   } AMIRequest;

   typedef struct packed {
      logic   valid;
      AMIData data;
      AMISize size;
   } AMIResponse;

   localparam int AMI_ARB_MAX_REQ = 16;
   typedef logic [3:0] AMIArbId;

   // Value driven on the memory port when no requester is selected.
   function automatic AMIRequest ami_idle_request();
      AMIRequest r;
      r      = '0;
      r.size = AMISize'(64);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ami_tag_fifo.sv
`default_nettype none
// =============================================================================
// ami_tag_fifo : first-word-fall-through FIFO of requester ids for reads
//                still waiting on their response.
// Rev 1.0
// =============================================================================
module ami_tag_fifo #(
   parameter int WIDTH     = 2,
   parameter int LOG_DEPTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_push,
   input  logic [WIDTH-1:0]     i_push_data,
   input  logic                 i_pop,
   output logic [WIDTH-1:0]     o_head,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [LOG_DEPTH:0]   o_count
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] c_DEPTH = (LOG_DEPTH+1)'(DEPTH);

   logic [WIDTH-1:0]     r_mem [DEPTH];
   logic [LOG_DEPTH-1:0] r_wr_ptr;
   logic [LOG_DEPTH-1:0] r_rd_ptr;
   logic [LOG_DEPTH:0]   r_count;
   logic                 w_push;
   logic                 w_pop;

   assign o_full  = (r_count == c_DEPTH);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/ami_port_arbiter.sv
`default_nettype none
// =============================================================================
// ami_port_arbiter : round-robin, lock-until-accepted sharing of one AMI port;
//                    in-order read responses routed back via a tag FIFO.
//                    Optional per-requester grant counters: AMI_ARB_STATS_EN.
// Rev 1.0
// =============================================================================
module ami_port_arbiter
   import AMITypes::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int TAG_LOG_DEPTH = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  AMIRequest            req_in [NUM_REQ],
   output logic [NUM_REQ-1:0]   req_grant_out,
   output AMIRequest            mem_req,
   input  logic                 mem_req_grant,
   input  AMIResponse           mem_resp,
   output logic                 mem_resp_grant,
   output AMIResponse           resp_out [NUM_REQ],
   input  logic [NUM_REQ-1:0]   resp_grant_in,
   output logic                 resp_orphan,
   output logic [31:0]          grant_count [NUM_REQ]
);

   localparam int ID_W = $clog2(NUM_REQ);
   localparam logic [ID_W:0]   c_NUM_REQ = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]      r_rr_ptr;
   logic                 r_lock_valid;
   logic [ID_W-1:0]      r_lock_id;
   logic                 r_orphan;

   logic [NUM_REQ-1:0]   w_elig;
   logic [ID_W-1:0]      w_sel;
   logic                 w_sel_valid;
   logic [ID_W:0]        w_idx;
   AMIRequest            w_mem_req;
   logic                 w_accept;

   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [TAG_LOG_DEPTH:0] w_fifo_count;
   logic [ID_W-1:0]      w_head;
   logic                 w_has_tag;
   logic                 w_pop;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = req_in[i].valid & (req_in[i].isWrite | ~w_fifo_full);
      end
   end

   // A held lock bypasses the rotating search entirely.
   always_comb begin
      w_sel       = r_lock_id;
      w_sel_valid = r_lock_valid;
      w_idx       = '0;
      if (!r_lock_valid) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(j);
            if (w_idx >= c_NUM_REQ) begin
               w_idx = w_idx - c_NUM_REQ;
            end
            if (!w_sel_valid && w_elig[w_idx[ID_W-1:0]]) begin
               w_sel       = w_idx[ID_W-1:0];
               w_sel_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_mem_req = ami_idle_request();
      if (rst_n && w_sel_valid) begin
         w_mem_req       = req_in[w_sel];
         w_mem_req.valid = w_elig[w_sel];
      end
   end

   assign mem_req  = w_mem_req;
   assign w_accept = w_mem_req.valid & mem_req_grant;

   always_comb begin
      req_grant_out = '0;
      if (w_accept) begin
         req_grant_out[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr     <= '0;
         r_lock_valid <= 1'b0;
         r_lock_id    <= '0;
      end else if (w_accept) begin
         r_rr_ptr     <= (w_sel == c_LAST_ID) ? '0 : w_sel + ID_W'(1);
         r_lock_valid <= 1'b0;
      end else if (!r_lock_valid && w_sel_valid) begin
         r_lock_valid <= 1'b1;
         r_lock_id    <= w_sel;
      end
   end

   ami_tag_fifo #(
      .WIDTH     (ID_W),
      .LOG_DEPTH (TAG_LOG_DEPTH)
   ) u_tag_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_accept & ~w_mem_req.isWrite),
      .i_push_data (w_sel),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   assign w_has_tag = (w_fifo_count != '0);

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_out[i] = '0;
         if (rst_n && w_has_tag && (w_head == ID_W'(i))) begin
            resp_out[i] = mem_resp;
         end
      end
   end

   // With no outstanding read the response is swallowed so the port never stalls.
   always_comb begin
      mem_resp_grant = 1'b0;
      if (rst_n) begin
         mem_resp_grant = w_has_tag ? (mem_resp.valid & resp_grant_in[w_head])
                                    : mem_resp.valid;
      end
   end

   assign w_pop = w_has_tag & mem_resp_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_orphan <= 1'b0;
      end else if (mem_resp.valid && w_fifo_empty) begin
         r_orphan <= 1'b1;
      end
   end

   assign resp_orphan = r_orphan;

`ifdef AMI_ARB_STATS_EN
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [31:0] r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt <= '0;
         end else if (w_accept && (w_sel == ID_W'(gi))) begin
            r_cnt <= r_cnt + 32'd1;
         end
      end
      assign grant_count[gi] = r_cnt;
   end
`else
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_no_stats
      assign grant_count[gi] = '0;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ami_port_arbiter.sv
`default_nettype none
// =============================================================================
// tb_ami_port_arbiter : randomized scoreboard bench for ami_port_arbiter.
// Rev 1.0
// =============================================================================
module tb_ami_port_arbiter;
   import AMITypes::*;

   localparam int N     = 4;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   AMIRequest        req_in [N];
   logic [N-1:0]     req_grant_out;
   AMIRequest        mem_req;
   logic             mem_req_grant;
   AMIResponse       mem_resp;
   logic             mem_resp_grant;
   AMIResponse       resp_out [N];
   logic [N-1:0]     resp_grant_in;
   logic             resp_orphan;
   logic [31:0]      grant_count [N];

   ami_port_arbiter #(.NUM_REQ(N), .TAG_LOG_DEPTH(5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_in         (req_in),
      .req_grant_out  (req_grant_out),
      .mem_req        (mem_req),
      .mem_req_grant  (mem_req_grant),
      .mem_resp       (mem_resp),
      .mem_resp_grant (mem_resp_grant),
      .resp_out       (resp_out),
      .resp_grant_in  (resp_grant_in),
      .resp_orphan    (resp_orphan),
      .grant_count    (grant_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic                req_v;
      logic [N-1:0]        gnt;
      logic [63:0]         addr;
      logic                wr;
      logic [N-1:0]        rv;
      logic [511:0]        rdata;
      logic                mrg;
      logic                orphan;
      logic [N-1:0][31:0]  cnt;
   } exp_t;

   exp_t          exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;

   // Reference model state
   int            m_rr;
   bit            m_lock;
   int            m_lock_id;
   int            tags[$];
   logic [511:0]  mq[$];
   bit            m_orphan;
   logic [31:0]   m_cnt [N];

   // Client and memory stimulus controls
   bit            cv [N];
   bit            cw [N];
   logic [63:0]   ca [N];
   int            gnt_pct  = 100;
   int            resp_pct = 0;
   int            rg_pct   = 100;
   bit            force_orphan = 1'b0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_rr = 0; m_lock = 0; m_lock_id = 0; m_orphan = 0;
      tags.delete();
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
   endtask

   task automatic drive_idle();
      for (int i = 0; i < N; i++) req_in[i] = '0;
      mem_req_grant = 1'b0;
      mem_resp      = '0;
      resp_grant_in = '0;
   endtask

   task automatic new_req(input int i, input bit w);
      cv[i] = 1'b1;
      cw[i] = w;
      ca[i] = {$urandom, $urandom};
   endtask

   task automatic step();
      exp_t          e;
      int            sel;
      bit            found, vld, acc, drove_mq, rv_in, had_tag;
      bit            elig [N];
      logic [N-1:0]  rg;
      logic [511:0]  rd;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         req_in[i].valid   = cv[i];
         req_in[i].isWrite = cw[i];
         req_in[i].addr    = ca[i];
         req_in[i].data    = {448'd0, ca[i]};
         req_in[i].size    = 64'd64;
      end
      mem_req_grant = ($urandom_range(99) < gnt_pct);
      for (int i = 0; i < N; i++) rg[i] = ($urandom_range(99) < rg_pct);
      resp_grant_in = rg;
      drove_mq = (mq.size() > 0) && ($urandom_range(99) < resp_pct);
      rd = drove_mq ? mq[0] : {$urandom, 416'd0, $urandom, $urandom};
      rv_in = drove_mq || force_orphan;
      mem_resp.valid = rv_in;
      mem_resp.data  = rd;
      mem_resp.size  = 64'd64;
      #1;
      // Expected arbitration outcome from the rotating-priority / lock rules
      found = 0; sel = 0; vld = 0;
      for (int i = 0; i < N; i++) elig[i] = cv[i] && (cw[i] || tags.size() < DEPTH);
      if (m_lock) begin
         sel = m_lock_id; found = 1; vld = elig[sel];
      end else begin
         for (int j = 0; j < N; j++) begin
            if (!found && elig[(m_rr + j) % N]) begin
               sel = (m_rr + j) % N; found = 1;
            end
         end
         vld = found;
      end
      acc = vld && mem_req_grant;
      had_tag = (tags.size() > 0);
      e.req_v = vld;
      e.gnt   = acc ? (N'(1) << sel) : '0;
      e.addr  = ca[sel];
      e.wr    = cw[sel];
      e.rv    = '0;
      if (rv_in && had_tag) e.rv[tags[0]] = 1'b1;
      e.rdata = rd;
      e.mrg   = had_tag ? (rv_in && rg[tags[0]]) : rv_in;
      e.orphan = m_orphan;
      for (int i = 0; i < N; i++) begin
`ifdef AMI_ARB_STATS_EN
         e.cnt[i] = m_cnt[i];
`else
         e.cnt[i] = '0;
`endif
      end
      exp_q.push_back(e);
      if (e.mrg && had_tag) void'(tags.pop_front());
      if (rv_in && !had_tag) m_orphan = 1'b1;
      if (e.mrg && drove_mq) void'(mq.pop_front());
      if (acc) begin
         if (!cw[sel]) begin
            tags.push_back(sel);
            mq.push_back({32'(sel), 416'd0, $urandom, $urandom});
         end
         m_cnt[sel] = m_cnt[sel] + 32'd1;
         m_rr   = (sel + 1) % N;
         m_lock = 0;
         cv[sel] = 0;
      end else if (!m_lock && found) begin
         m_lock = 1; m_lock_id = sel;
      end
   endtask

   task automatic drain();
      int  guard = 0;
      bit  busy;
      gnt_pct = 100; resp_pct = 100; rg_pct = 100;
      busy = 1;
      while (busy && guard < 300) begin
         busy = (mq.size() > 0) || (tags.size() > 0);
         for (int i = 0; i < N; i++) busy = busy || cv[i];
         if (busy) begin
            step();
            guard++;
         end
      end
      n_tests++;
      if (busy) begin
         n_fail++;
         $display("FAIL drain: still busy after %0d cycles, required idle", guard);
      end
   endtask

   // Monitor: pops one expectation per cycle and compares the live outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("req_valid", mem_req.valid, e.req_v);
            chk("req_grant", req_grant_out, e.gnt);
            if (e.req_v) begin
               chk("req_addr", mem_req.addr, e.addr);
               chk("req_write", mem_req.isWrite, e.wr);
            end
            chk("resp_grant", mem_resp_grant, e.mrg);
            for (int i = 0; i < N; i++) begin
               chk("resp_valid", resp_out[i].valid, e.rv[i]);
               if (e.rv[i]) chk("resp_data", resp_out[i].data, e.rdata);
            end
            chk("orphan", resp_orphan, e.orphan);
            for (int i = 0; i < N; i++) chk("grant_count", grant_count[i], e.cnt[i]);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      logic [N-1:0] rvs;
      for (int i = 0; i < N; i++) rvs[i] = resp_out[i].valid;
      chk({tag, "_req_valid"}, mem_req.valid, 1'b0);
      chk({tag, "_req_size"}, mem_req.size, 64'd64);
      chk({tag, "_req_grant"}, req_grant_out, '0);
      chk({tag, "_resp_grant"}, mem_resp_grant, 1'b0);
      chk({tag, "_resp_valid"}, rvs, '0);
      chk({tag, "_orphan"}, resp_orphan, 1'b0);
      for (int i = 0; i < N; i++) chk({tag, "_grant_count"}, grant_count[i], 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive_idle();
      for (int i = 0; i < N; i++) begin cv[i] = 0; cw[i] = 0; ca[i] = '0; end
      model_reset();
      // Live inputs during reset must not leak through
      req_in[0].valid = 1'b1;
      mem_req_grant   = 1'b1;
      mem_resp.valid  = 1'b1;
      resp_grant_in   = '1;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("rst");
      drive_idle();
      rst_n = 1'b1;

      // Three back-to-back writes from requester 2
      for (int k = 0; k < 3; k++) begin
         new_req(2, 1'b1);
         step();
      end
      drain();

      // All requesters reading continuously
      resp_pct = 70;
      for (int k = 0; k < 24; k++) begin
         for (int i = 0; i < N; i++) if (!cv[i]) new_req(i, 1'b0);
         step();
      end
      drain();

      // Lock holds requester 1 while the port refuses
      gnt_pct = 0;
      new_req(1, 1'b0);
      step(); step();
      new_req(0, 1'b0);
      step(); step(); step();
      gnt_pct = 100;
      step(); step();
      drain();

      // Fill the tag FIFO, stall the next read, let a write through
      resp_pct = 0;
      for (int k = 0; k < 40; k++) begin
         if (!cv[0]) new_req(0, 1'b0);
         step();
      end
      new_req(1, 1'b1);
      step(); step();
      resp_pct = 100;
      step();
      resp_pct = 0;
      step(); step();
      drain();

      // Response held off by the requester
      new_req(2, 1'b0);
      step();
      resp_pct = 100; rg_pct = 0;
      step(); step(); step();
      rg_pct = 100;
      step();
      drain();

      // Orphan response
      force_orphan = 1'b1;
      step();
      force_orphan = 1'b0;
      step(); step();

      // Randomized traffic
      gnt_pct = 60; resp_pct = 50; rg_pct = 60;
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N; i++)
            if (!cv[i] && $urandom_range(99) < 30) new_req(i, 1'($urandom_range(1)));
         step();
      end

      // Asynchronous reset in the middle of a read burst
      gnt_pct = 100; resp_pct = 0;
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < N; i++) if (!cv[i]) new_req(i, 1'b0);
         step();
      end
      @(negedge clk);
      mem_resp.valid = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      @(posedge clk);
      #2;
      check_reset_outputs("arst_hold");
      for (int i = 0; i < N; i++) cv[i] = 0;
      model_reset();
      rst_n = 1'b1;
      drain();
      gnt_pct = 70; resp_pct = 60; rg_pct = 70;
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < N; i++)
            if (!cv[i] && $urandom_range(99) < 30) new_req(i, 1'($urandom_range(1)));
         step();
      end
      drain();

      repeat (2) @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
